// File: rtl/branch_cmp_seq_pkg.sv
// Shared definitions for the multi-cycle branch-condition unit:
// funct3 encodings, FSM state type and result decode helpers.
package branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // funct3 values 010/011 are not branch encodings
    function automatic logic br_illegal_f(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic br_taken_f(input logic [2:0] op, input logic eq, input logic lt);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_BEQ:           taken = eq;
            BR_BNE:           taken = !eq;
            BR_BLT, BR_BLTU:  taken = lt;
            BR_BGE, BR_BGEU:  taken = !lt;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_cmp_seq_if.sv
// Request/result handshake bundle between register-read, the branch unit and PC-select.
interface branch_cmp_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] data_a;
    logic [XLEN-1:0] data_b;
    logic [2:0]      br_op;
    logic            out_valid;
    logic            out_ready;
    logic            br_taken;
    logic            br_eq;
    logic            br_lt;
    logic            illegal_op;

    modport slave (
        input  flush, in_valid, data_a, data_b, br_op, out_ready,
        output in_ready, out_valid, br_taken, br_eq, br_lt, illegal_op
    );

    modport master (
        output flush, in_valid, data_a, data_b, br_op, out_ready,
        input  in_ready, out_valid, br_taken, br_eq, br_lt, illegal_op
    );
endinterface

// File: rtl/branch_cmp_seq_cmp_chunk.sv
// Combinational unsigned compare of one W-bit operand slice.
module cmp_chunk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_eq_c,
    output logic         o_lt_c
);
    assign o_eq_c = (i_a == i_b);
    assign o_lt_c = (i_a <  i_b);
endmodule

// File: rtl/branch_cmp_seq.sv
// Multi-cycle branch-condition unit: compares operands MSB-first, CHUNK bits per
// cycle, with optional early exit on the first differing slice.
module branch_cmp_seq
    import branch_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CHUNK      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_cmp_seq_if.slave   bus
);
    localparam int unsigned    NCHUNK    = XLEN / CHUNK;
    localparam int unsigned    IW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [XLEN-1:0] SIGN_MASK = {1'b1, {(XLEN-1){1'b0}}};

    if (XLEN % CHUNK != 0) begin : g_bad_chunk
        $error("branch_cmp_seq: XLEN must be a multiple of CHUNK");
    end

    state_t          r_state;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [2:0]      r_op;
    logic [IW-1:0]   r_idx;
    logic            r_illegal_pend;
    logic            r_differ;
    logic            r_lt_first;
    logic            r_out_valid;
    logic            r_taken;
    logic            r_eq;
    logic            r_lt;
    logic            r_illegal;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic             w_ch_eq;
    logic             w_ch_lt;
    logic             w_exit;
    logic             w_fin_eq;
    logic             w_fin_lt;

    assign w_a_chunk = CHUNK'(r_a >> (32'(r_idx) * CHUNK));
    assign w_b_chunk = CHUNK'(r_b >> (32'(r_idx) * CHUNK));

    cmp_chunk #(.W(CHUNK)) u_cmp_chunk (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .o_eq_c (w_ch_eq),
        .o_lt_c (w_ch_lt)
    );

    // A difference recorded in an earlier slice overrides anything seen later
    assign w_exit   = (!w_ch_eq && EARLY_EXIT) || (r_idx == '0);
    assign w_fin_eq = !r_differ && w_ch_eq;
    assign w_fin_lt = r_differ ? r_lt_first : w_ch_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_idx          <= '0;
            r_illegal_pend <= 1'b0;
            r_differ       <= 1'b0;
            r_lt_first     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_taken        <= 1'b0;
            r_eq           <= 1'b0;
            r_lt           <= 1'b0;
            r_illegal      <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= IDLE;
            r_differ    <= 1'b0;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Flipping the sign bit maps signed order onto unsigned order
                        r_a            <= bus.data_a ^ (bus.br_op[1] ? '0 : SIGN_MASK);
                        r_b            <= bus.data_b ^ (bus.br_op[1] ? '0 : SIGN_MASK);
                        r_op           <= bus.br_op;
                        r_idx          <= IW'(NCHUNK - 1);
                        r_illegal_pend <= br_illegal_f(bus.br_op);
                        r_differ       <= 1'b0;
                        r_lt_first     <= 1'b0;
                        r_state        <= CMP;
                    end
                end
                CMP: begin
                    // Illegal ops take one slot so every result appears one edge after accept or later
                    if (r_illegal_pend) begin
                        r_illegal   <= 1'b1;
                        r_taken     <= 1'b0;
                        r_eq        <= 1'b0;
                        r_lt        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_exit) begin
                        r_eq        <= w_fin_eq;
                        r_lt        <= w_fin_lt;
                        r_taken     <= br_taken_f(r_op, w_fin_eq, w_fin_lt);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        if (!w_ch_eq && !r_differ) begin
                            r_differ   <= 1'b1;
                            r_lt_first <= w_ch_lt;
                        end
                        r_idx <= r_idx - IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_taken     <= 1'b0;
                        r_eq        <= 1'b0;
                        r_lt        <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE) && !bus.flush;
    assign bus.out_valid  = r_out_valid;
    assign bus.br_taken   = r_taken;
    assign bus.br_eq      = r_eq;
    assign bus.br_lt      = r_lt;
    assign bus.illegal_op = r_illegal;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Bench for branch_cmp_seq: three builds (early exit, full scan, single chunk) share
// one stimulus stream; results are checked against a queued reference model.
module tb_branch_cmp_seq;
    import branch_pkg::*;

    typedef struct packed {
        logic       taken;
        logic       eq;
        logic       lt;
        logic       ill;
        logic [3:0] lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    branch_cmp_seq_if #(.XLEN(32)) if_m ();
    branch_cmp_seq_if #(.XLEN(32)) if_e0 ();
    branch_cmp_seq_if #(.XLEN(32)) if_c32 ();

    assign if_e0.flush     = if_m.flush;
    assign if_e0.in_valid  = if_m.in_valid;
    assign if_e0.data_a    = if_m.data_a;
    assign if_e0.data_b    = if_m.data_b;
    assign if_e0.br_op     = if_m.br_op;
    assign if_e0.out_ready = if_m.out_ready;
    assign if_c32.flush     = if_m.flush;
    assign if_c32.in_valid  = if_m.in_valid;
    assign if_c32.data_a    = if_m.data_a;
    assign if_c32.data_b    = if_m.data_b;
    assign if_c32.br_op     = if_m.br_op;
    assign if_c32.out_ready = if_m.out_ready;

    branch_cmp_seq #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b1))
        u_m   (.clk(clk), .rst_n(rst_n), .bus(if_m));
    branch_cmp_seq #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b0))
        u_e0  (.clk(clk), .rst_n(rst_n), .bus(if_e0));
    branch_cmp_seq #(.XLEN(32), .CHUNK(32), .EARLY_EXIT(1'b1))
        u_c32 (.clk(clk), .rst_n(rst_n), .bus(if_c32));

    // Reference: direct whole-word compare plus first-differing-slice latency
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input int unsigned chunk,
                                   input bit early);
        exp_t        e;
        logic [31:0] d;
        logic [63:0] s;
        int unsigned n;
        bit          found;
        e.ill = (op == 3'b010) || (op == 3'b011);
        e.eq  = (a == b);
        e.lt  = op[1] ? (a < b) : ($signed(a) < $signed(b));
        case (op)
            3'b000:         e.taken = e.eq;
            3'b001:         e.taken = !e.eq;
            3'b100, 3'b110: e.taken = e.lt;
            3'b101, 3'b111: e.taken = !e.lt;
            default:        e.taken = 1'b0;
        endcase
        n     = 32 / chunk;
        e.lat = 4'(n);
        d     = a ^ b;
        found = 1'b0;
        if (early) begin
            for (int k = 0; k < int'(n); k++) begin
                s = 64'(d) >> ((n - 1 - k) * chunk);
                s = s & ((64'd1 << chunk) - 64'd1);
                if (!found && s != 64'd0) begin
                    found = 1'b1;
                    e.lat = 4'(k + 1);
                end
            end
        end
        if (e.ill) begin
            e.taken = 1'b0;
            e.eq    = 1'b0;
            e.lt    = 1'b0;
            e.lat   = 4'd1;
        end
        return e;
    endfunction

    // {in_ready, out_valid, br_taken, br_eq, br_lt, illegal_op}
    function automatic logic [5:0] obs(input int i);
        case (i)
            0:       return {if_m.in_ready, if_m.out_valid, if_m.br_taken,
                             if_m.br_eq, if_m.br_lt, if_m.illegal_op};
            1:       return {if_e0.in_ready, if_e0.out_valid, if_e0.br_taken,
                             if_e0.br_eq, if_e0.br_lt, if_e0.illegal_op};
            default: return {if_c32.in_ready, if_c32.out_valid, if_c32.br_taken,
                             if_c32.br_eq, if_c32.br_lt, if_c32.illegal_op};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic pop(input int i, output exp_t e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [5:0] o;
        exp_t       e;
        bit         seen [3];
        q0.push_back(model(a, b, op, 8, 1'b1));
        q1.push_back(model(a, b, op, 8, 1'b0));
        q2.push_back(model(a, b, op, 32, 1'b1));
        @(negedge clk);
        o = obs(0);
        chk("ready_before_op", 32'(o[5]), 32'd1);
        if_m.data_a    = a;
        if_m.data_b    = b;
        if_m.br_op     = op;
        if_m.in_valid  = 1'b1;
        if_m.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        @(posedge clk);
        #1 if_m.in_valid = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                o = obs(i);
                if (!seen[i] && o[4]) begin
                    seen[i] = 1'b1;
                    pop(i, e);
                    chk($sformatf("op%0h_inst%0d_taken", op, i), 32'(o[3]), 32'(e.taken));
                    chk($sformatf("op%0h_inst%0d_eq", op, i),    32'(o[2]), 32'(e.eq));
                    chk($sformatf("op%0h_inst%0d_lt", op, i),    32'(o[1]), 32'(e.lt));
                    chk($sformatf("op%0h_inst%0d_ill", op, i),   32'(o[0]), 32'(e.ill));
                    chk($sformatf("op%0h_inst%0d_latency", op, i), 32'(cyc), 32'(e.lat));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!seen[i]) begin
                chk($sformatf("op%0h_inst%0d_timeout", op, i), 32'd0, 32'd1);
                pop(i, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  o;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n          = 1'b0;
        if_m.flush     = 1'b0;
        if_m.in_valid  = 1'b0;
        if_m.data_a    = '0;
        if_m.data_b    = '0;
        if_m.br_op     = '0;
        if_m.out_ready = 1'b1;
        #12;
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            chk($sformatf("reset_outputs_inst%0d", i), 32'(o[4:0]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, BR_BLT);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, BR_BLTU);
        run_op(32'h1234_5678, 32'h1234_5678, BR_BEQ);
        run_op(32'h1234_5678, 32'h1234_5678, BR_BNE);
        run_op(32'h0000_0100, 32'h0000_00FF, BR_BGE);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, BR_BGEU);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, BR_BGE);
        run_op(32'h1234_5600, 32'h1234_5680, BR_BLT);
        run_op(32'hABCD_0001, 32'hABCD_0000, BR_BLTU);
        run_op(32'h0000_0007, 32'h0000_0007, 3'b010);
        run_op(32'h0000_0001, 32'h0000_0002, 3'b011);
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k % 2 == 0) ? {ra[31:16], 16'($urandom)} : $urandom;
            run_op(ra, rb, 3'($urandom_range(4, 7)));
        end

        // Backpressure: result held in DONE while out_ready is low
        @(negedge clk);
        if_m.data_a    = 32'hA5A5_A5A5;
        if_m.data_b    = 32'hA5A5_A5A5;
        if_m.br_op     = BR_BEQ;
        if_m.in_valid  = 1'b1;
        if_m.out_ready = 1'b0;
        @(posedge clk);
        #1 if_m.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        o = obs(0);
        chk("bp_first_valid", 32'(o[4:2]), 32'b111);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            o = obs(0);
            chk("bp_hold_main", 32'(o), 32'b011100);
            o = obs(1);
            chk("bp_hold_full_scan", 32'(o), 32'b011100);
        end
        @(negedge clk);
        if_m.out_ready = 1'b1;
        @(posedge clk);
        #1;
        o = obs(0);
        chk("bp_release_ready", 32'(o[5:4]), 32'b10);

        // Flush during the second compare cycle discards the op
        @(negedge clk);
        if_m.data_a   = 32'h0F0F_0F0F;
        if_m.data_b   = 32'h0F0F_0F0F;
        if_m.br_op    = BR_BEQ;
        if_m.in_valid = 1'b1;
        @(posedge clk);
        #1 if_m.in_valid = 1'b0;
        @(posedge clk);
        #1 if_m.flush = 1'b1;
        @(negedge clk);
        o = obs(0);
        chk("flush_ready_low", 32'(o[5]), 32'd0);
        @(posedge clk);
        #1 if_m.flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            o = obs(0);
            chk("flush_no_valid_main", 32'(o[4:0]), 32'd0);
            o = obs(1);
            chk("flush_no_valid_full_scan", 32'(o[4]), 32'd0);
            @(posedge clk);
            #1;
        end
        o = obs(0);
        chk("flush_ready_back", 32'(o[5]), 32'd1);

        // Asynchronous reset mid-compare clears outputs immediately
        @(negedge clk);
        if_m.data_a   = 32'h1111_1111;
        if_m.data_b   = 32'h1111_1111;
        if_m.br_op    = BR_BEQ;
        if_m.in_valid = 1'b1;
        @(posedge clk);
        #1 if_m.in_valid = 1'b0;
        @(posedge clk);
        #1;
        o = obs(2);
        chk("rst_pre_single_chunk_valid", 32'(o[4:2]), 32'b111);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            chk($sformatf("rst_mid_inst%0d", i), 32'(o[4:0]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            o = obs(0);
            chk("rst_no_result_main", 32'(o[4]), 32'd0);
        end
        run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, BR_BLT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
